ideal_mem_hs: RTL
=================

Name: ideal_mem_hs

Overview:
- Parametrised, handshaked successor to the lab's ideal dual-read/single-write memory.
- Adds generic data width, configurable depth, a fixed read pipeline latency and per-port valid/ready with backpressure.
- Adds write-first read-during-write ordering and out-of-range error reporting.
- Sits between the CPU/multi-cycle datapath and the simulation memory image; contents are loaded at simulation start from the INITMEM plusarg.

Parameters:
- ADDR_WIDTH, 14, byte-address width; word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32, word width; must be a multiple of 8; strobe width SW = DATA_WIDTH/8.
- MEM_DEPTH, 2**(ADDR_WIDTH-2), number of implemented words; must be <= 2**(ADDR_WIDTH-2).
- RD_LATENCY, 1, cycles from read request acceptance to response valid; legal range 1..4.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_addr  in  ADDR_WIDTH-2  word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_strb  in  SW  byte enables; bit i covers wr_data[8i+7:8i].
- rdN_req_valid  in  1  read request on port N (N = 1, 2).
- rdN_req_ready  out  1  read request accept.
- rdN_addr  in  ADDR_WIDTH-2  read word address.
- rdN_resp_valid  out  1  response valid.
- rdN_resp_ready  in  1  consumer accepts response.
- rdN_data  out  DATA_WIDTH  read data; zero when rdN_resp_valid = 0.
- rdN_err  out  1  address >= MEM_DEPTH; qualified by rdN_resp_valid.
- wr_err  out  1  one-cycle pulse: accepted write to address >= MEM_DEPTH.

Behaviour:

Reset:
- While rst = 1: wr_ready = 0, rdN_req_ready = 0, rdN_resp_valid = 0, rdN_data = 0, rdN_err = 0, wr_err = 0.
- All pipeline valid bits are cleared. Array contents are retained (no clear).
- Reset asserted mid-operation discards all in-flight reads with no response. A write accepted in the same cycle as rst = 1 does not occur, because wr_ready = 0.
- First accept is possible in the first cycle with rst = 0.

Write port:
- wr_ready = ~rst.
- Fire = wr_valid & wr_ready. On fire, each byte i with wr_strb[i] = 1 is updated at the clock edge; other bytes keep their old value.
- A write with wr_strb = 0 is accepted and has no effect.
- An out-of-range write is dropped; wr_err = 1 in the following cycle.

Read pipeline (each port independent):
- The port has RD_LATENCY stages. Stage k holds {valid, data, err}.
- stall = rdN_resp_valid & ~rdN_resp_ready.
- rdN_req_ready = ~rst & ~stall.
- While stall = 1 the whole pipeline freezes. Output data and err stay stable while valid and not accepted.
- The array is sampled in the accept cycle. Read data is therefore fixed at acceptance, and later writes do not alter a response already in flight.
- Accepted request at edge T with no stalls gives rdN_resp_valid = 1 in the cycle after edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle.
- Back-to-back requests sustain one response per cycle.
- A bubble (no request) propagates as valid = 0.

Read-during-write:
- A read accepted in the same cycle as a write fire to the same in-range address returns the merged new word: strobed bytes come from wr_data, other bytes from the old word.
- Both ports apply this forwarding, and both may read the same address simultaneously.

Out-of-range read:
- Returns data = 0, err = 1, with the same latency.

Address handling:
- No wrap-around: addresses >= MEM_DEPTH are never aliased.

Test Plan:
- Reset then write: rst for 2 cycles, then wr addr 0x10, data 0xDEADBEEF, strb 0xF; read port 1 addr 0x10 with RD_LATENCY=1 -> rd1_data = 0xDEADBEEF one cycle later, rd1_err = 0. During reset, all ready/valid outputs = 0.
- Byte strobes: word 0x20 = 0x11223344; write 0xAABBCCDD with strb 0b0101 -> read returns 0x11BB33DD.
- Read-during-write: same cycle, write addr 5 = 0x0000FFFF (strb 0xF) and rd1/rd2 both request addr 5 -> both ports return 0x0000FFFF.
- Backpressure, RD_LATENCY=3: issue reads to addrs 1, 2, 3, 4 back-to-back; hold rd2_resp_ready = 0 for 3 cycles when the first response appears -> rd2_req_ready = 0 during the hold; data for addr 1 stays stable; responses arrive in order 1, 2, 3, 4 with none lost or duplicated.
- Out of range, MEM_DEPTH=1000: read addr 1000 -> data 0, rd1_err = 1. Write addr 1023 -> wr_err pulses for 1 cycle; a subsequent read of addr 1023 still returns err and addr 999 is unchanged.
- Reset mid-flight, RD_LATENCY=4: accept 2 reads, assert rst for 1 cycle at the 2nd cycle -> no rd1_resp_valid ever appears for those requests; memory retains the previously written values.

Source files
------------

// File: rtl/ideal_mem_hs_if.sv
// Handshake bundle between a requester (CPU/datapath) and ideal_mem_hs:
// one write port and two independent read ports with request/response
// valid/ready pairs.
interface ideal_mem_hs_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic                  wr_err;

  logic                  rd1_req_valid;
  logic                  rd1_req_ready;
  logic [AW-1:0]         rd1_addr;
  logic                  rd1_resp_valid;
  logic                  rd1_resp_ready;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic                  rd1_err;

  logic                  rd2_req_valid;
  logic                  rd2_req_ready;
  logic [AW-1:0]         rd2_addr;
  logic                  rd2_resp_valid;
  logic                  rd2_resp_ready;
  logic [DATA_WIDTH-1:0] rd2_data;
  logic                  rd2_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb,
    input  wr_ready, wr_err,
    output rd1_req_valid, rd1_addr, rd1_resp_ready,
    input  rd1_req_ready, rd1_resp_valid, rd1_data, rd1_err,
    output rd2_req_valid, rd2_addr, rd2_resp_ready,
    input  rd2_req_ready, rd2_resp_valid, rd2_data, rd2_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb,
    output wr_ready, wr_err,
    input  rd1_req_valid, rd1_addr, rd1_resp_ready,
    output rd1_req_ready, rd1_resp_valid, rd1_data, rd1_err,
    input  rd2_req_valid, rd2_addr, rd2_resp_ready,
    output rd2_req_ready, rd2_resp_valid, rd2_data, rd2_err
  );
endinterface

// File: rtl/ideal_mem_hs.sv
// Ideal dual-read/single-write word memory with valid/ready handshakes.
// Reads sample the array (with write-first forwarding) in the accept cycle
// and travel through a RD_LATENCY-deep pipeline that freezes on
// backpressure. Out-of-range accesses are never aliased: writes are dropped
// and flagged on wr_err, reads return zero data with err set.
module ideal_mem_hs #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 2 ** (ADDR_WIDTH - 2),
  parameter int RD_LATENCY = 1
) (
  input logic         clk,
  input logic         rst,
  ideal_mem_hs_if.slave bus
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so a depth of exactly 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_L = MEM_DEPTH[AW:0];

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic          wr_fire;
  logic          wr_in_range;
  logic [IW-1:0] wr_idx;
  logic          wr_err_q;

  assign bus.wr_ready = ~rst;
  assign wr_fire      = bus.wr_valid & ~rst;
  assign wr_in_range  = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign wr_idx       = bus.wr_addr[IW-1:0];

  // Byte-masked array update for an accepted in-range write.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) begin
      for (int i = 0; i < SW; i++) begin
        if (bus.wr_strb[i]) mem[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  // One-cycle error pulse following a dropped out-of-range write.
  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_fire & ~wr_in_range;
  end

  assign bus.wr_err = wr_err_q & ~rst;

  // Both read ports share one implementation; map the named interface
  // signals onto small per-port arrays.
  logic                  req_valid  [2];
  logic [AW-1:0]         rd_addr    [2];
  logic                  resp_ready [2];
  logic                  req_ready  [2];
  logic                  resp_valid [2];
  logic [DATA_WIDTH-1:0] resp_data  [2];
  logic                  resp_err   [2];

  assign req_valid[0]  = bus.rd1_req_valid;
  assign rd_addr[0]    = bus.rd1_addr;
  assign resp_ready[0] = bus.rd1_resp_ready;
  assign req_valid[1]  = bus.rd2_req_valid;
  assign rd_addr[1]    = bus.rd2_addr;
  assign resp_ready[1] = bus.rd2_resp_ready;

  assign bus.rd1_req_ready  = req_ready[0];
  assign bus.rd1_resp_valid = resp_valid[0];
  assign bus.rd1_data       = resp_data[0];
  assign bus.rd1_err        = resp_err[0];
  assign bus.rd2_req_ready  = req_ready[1];
  assign bus.rd2_resp_valid = resp_valid[1];
  assign bus.rd2_data       = resp_data[1];
  assign bus.rd2_err        = resp_err[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RD_LATENCY-1:0] v_q;
    logic [RD_LATENCY-1:0] e_q;
    logic [DATA_WIDTH-1:0] d_q [RD_LATENCY];
    logic                  stall;
    logic                  fire;
    logic                  in_range;
    logic                  hit;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign resp_valid[p] = v_q[RD_LATENCY-1] & ~rst;
    assign stall         = resp_valid[p] & ~resp_ready[p];
    assign req_ready[p]  = ~rst & ~stall;
    assign fire          = req_valid[p] & req_ready[p];
    assign in_range      = ({1'b0, rd_addr[p]} < DEPTH_L);
    assign idx           = rd_addr[p][IW-1:0];
    assign hit           = wr_fire & wr_in_range & (bus.wr_addr == rd_addr[p]);

    // Word seen by a read accepted now: old contents merged with the
    // strobed bytes of a same-cycle write to the same word.
    always_comb begin
      rd_word = '0;
      if (in_range) begin
        rd_word = mem[idx];
        if (hit) begin
          for (int i = 0; i < SW; i++) begin
            if (bus.wr_strb[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
          end
        end
      end
    end

    // Response pipeline; holds every stage while the output is stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else if (!stall) begin
        v_q[0] <= fire;
        e_q[0] <= fire & ~in_range;
        d_q[0] <= fire ? rd_word : '0;
        for (int k = 1; k < RD_LATENCY; k++) begin
          v_q[k] <= v_q[k-1];
          e_q[k] <= e_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign resp_data[p] = resp_valid[p] ? d_q[RD_LATENCY-1] : '0;
    assign resp_err[p]  = resp_valid[p] & e_q[RD_LATENCY-1];
  end

endmodule
